// File: rtl/fp_add_sched.sv
// fp_add_sched: round-robin scheduler that time-shares one external FP adder
// among NUM_REQ requesters. One operation is in flight at a time. The winner's
// operands are held on fpa_a/fpa_b for ADD_LAT cycles. The adder output is then
// captured and returned, tagged with the requester id.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   - Request side: req_ready is a combinational function of req_valid, and
//     only the granted requester sees ready. A requester must not depend on
//     req_ready before it raises req_valid.
//   - Response side: once rsp_valid is high, rsp_id and rsp_data hold steady
//     until rsp_ready is seen high on a rising edge.
//
// dbg_state and dbg_rr_ptr expose the internal FSM state and the
// round-robin pointer so that checkers can bind to them.
module fp_add_sched #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           fpa_a,
  output logic [31:0]           fpa_b,
  input  logic [31:0]           fpa_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  busy,
  output logic [1:0]            dbg_state,
  output logic [IDW-1:0]        dbg_rr_ptr
);

  // The counter must hold ADD_LAT-1. It is kept at least one bit wide so that ADD_LAT=1 still works.
  localparam int              CW         = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CW-1:0]   P_CNT_INIT = CW'(ADD_LAT - 1);
  localparam logic [IDW:0]    P_NR       = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0]  P_LAST     = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_fpa_a;
  logic [31:0]     r_fpa_b;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [31:0]     r_rsp_data;

  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic [IDW:0]    w_idx;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;

  // Round-robin search: the first valid requester wins, starting at r_rr_ptr and wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
      if (w_idx >= P_NR) begin
        w_idx = w_idx - P_NR;
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[IDW-1:0];
      end
    end
  end

  // Select the operands of the winning requester.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == IDW'(k)) begin
        w_sel_a = req_a[32*k +: 32];
        w_sel_b = req_b[32*k +: 32];
      end
    end
  end

  // The pointer moves to the requester just after the winner, wrapping NUM_REQ-1 -> 0.
  assign w_ptr_nxt = (w_grant == P_LAST) ? '0 : w_grant + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> BUSY on accept, BUSY -> RESP when the countdown expires, RESP -> IDLE on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found)      w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == '0)  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready)    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: a one-hot grant only while IDLE and out of reset, and busy for any state other than IDLE.
  always_comb begin
    req_ready = '0;
    busy      = (r_state != S_IDLE);
    if ((r_state == S_IDLE) && !rst && w_found) begin
      req_ready = NUM_REQ'(1) << w_grant;
    end
  end

  // Datapath: latch operands on accept, count down the adder latency, capture the sum, and drop the response on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_fpa_a     <= '0;
      r_fpa_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_fpa_a  <= w_sel_a;
            r_fpa_b  <= w_sel_b;
            r_rsp_id <= w_grant;
            r_rr_ptr <= w_ptr_nxt;
            r_cnt    <= P_CNT_INIT;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= fpa_out;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign fpa_a      = r_fpa_a;
  assign fpa_b      = r_fpa_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign dbg_state  = r_state;
  assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: directed scenarios plus a randomized run.
// A stand-in adder model sits behind fpa_a/fpa_b. The randomized run is
// checked against a transaction-level timeline model with a scoreboard queue.
module tb_fp_add_sched;

  localparam int NUM_REQ = 4;
  localparam int ADD_LAT = 2;
  localparam int IDW     = 2;
  localparam int W       = IDW + 32;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [31:0]           fpa_a;
  logic [31:0]           fpa_b;
  logic [31:0]           fpa_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;
  logic                  busy;
  logic [1:0]            dbg_state;
  logic [IDW-1:0]        dbg_rr_ptr;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  fp_add_sched #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .fpa_a      (fpa_a),
    .fpa_b      (fpa_b),
    .fpa_out    (fpa_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder. It returns the true sum for 1.0 + 2.0 and a bit-mixing function for any other operands.
  function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a + {b[15:0], b[31:16]}) ^ 32'h1357_9BDF;
  endfunction

  // The result appears ADD_LAT-1 edges after the operands settle, so it is ready during the last BUSY cycle.
  logic [31:0] add_q;
  always_ff @(posedge clk) add_q <= adder_fn(fpa_a, fpa_b);
  assign fpa_out = add_q;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (fpa_a !== 32'h0 || fpa_b !== 32'h0) begin failures++; $display("FAIL reset_fpa: got %h/%h expected 0/0", fpa_a, fpa_b); end
    checks++; if (rsp_id !== 2'd0 || rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp: got id %0d data %h expected 0/0", rsp_id, rsp_data); end
    checks++; if (dbg_rr_ptr !== 2'd0 || dbg_state !== 2'd0) begin failures++; $display("FAIL reset_ptr_state: got %0d/%0d expected 0/0", dbg_rr_ptr, dbg_state); end
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
  endtask

  // 1.0 + 2.0 from requester 0: the operands hold for two cycles and the response appears at t+3.
  task automatic test_basic();
    do_reset();
    req_a = {$urandom, $urandom, $urandom, 32'h3F80_0000};
    req_b = {$urandom, $urandom, $urandom, 32'h4000_0000};
    req_valid = 4'b0001; rsp_ready = 1'b0; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL basic_grant: got %b expected 0001", req_ready); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      req_valid = 4'(c * 5); req_a = {4{$urandom}}; req_b = {4{$urandom}}; #1;
      checks++; if (fpa_a !== 32'h3F80_0000 || fpa_b !== 32'h4000_0000) begin failures++; $display("FAIL basic_fpa_t%0d: got %h/%h expected 3f800000/40000000", c, fpa_a, fpa_b); end
      checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL basic_busy_t%0d: got busy %b valid %b ready %b expected 1/0/0000", c, busy, rsp_valid, req_ready); end
    end
    @(negedge clk); req_valid = '0; rsp_ready = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h4040_0000 || rsp_id !== 2'd0) begin failures++; $display("FAIL basic_rsp: got v %b id %0d data %h expected 1/0/40400000", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk); rsp_ready = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle: got v %b busy %b expected 0/0", rsp_valid, busy); end
  endtask

  // With all requesters valid, grants go 0,1,2,3,0, one every ADD_LAT+2 cycles.
  task automatic test_rr_order();
    int n_acc = 0;
    int last  = -1;
    logic [3:0] exp_rdy;
    do_reset();
    req_valid = 4'hF; rsp_ready = 1'b1;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready !== 4'b0) begin
        exp_rdy = 4'(1 << (n_acc % 4));
        checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant_%0d: got %b expected %b", n_acc, req_ready, exp_rdy); end
        if (last >= 0) begin
          checks++; if (c - last !== ADD_LAT + 2) begin failures++; $display("FAIL rr_spacing_%0d: got %0d expected %0d", n_acc, c - last, ADD_LAT + 2); end
        end
        last = c;
        n_acc++;
      end
    end
    checks++; if (n_acc !== 5) begin failures++; $display("FAIL rr_accept_count: got %0d expected 5", n_acc); end
    req_valid = '0;
    repeat (4) @(negedge clk);
  endtask

  // Pointer wrap: after granting requester 2 the pointer is 3, so a lone req1 wins and the pointer becomes 2.
  task automatic test_ptr_wrap();
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_first: got %b expected 0100", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dbg_rr_ptr !== 2'd3 || busy !== 1'b0) begin failures++; $display("FAIL wrap_ptr3: got ptr %0d busy %b expected 3/0", dbg_rr_ptr, busy); end
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL wrap_req1: got %b expected 0010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (dbg_rr_ptr !== 2'd2) begin failures++; $display("FAIL wrap_ptr2: got %0d expected 2", dbg_rr_ptr); end
    repeat (3) @(negedge clk);
    req_valid = 4'b0101; #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_req2_first: got %b expected 0100", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);
  endtask

  // Response stalled for 5 cycles, then a handshake while req1 is already waiting.
  task automatic test_backpressure();
    logic [31:0] exp_d;
    do_reset();
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    exp_d = adder_fn(req_a[31:0], req_b[31:0]);
    rsp_ready = 1'b0; req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant: got %b expected 0001", req_ready); end
    @(negedge clk); req_valid = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req_a = {4{$urandom}}; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp_d) begin failures++; $display("FAIL bp_hold_%0d: got v %b id %0d data %h expected 1/0/%h", i, rsp_valid, rsp_id, rsp_data, exp_d); end
      checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_ready_%0d: got %b expected 0000", i, req_ready); end
    end
    @(negedge clk); rsp_ready = 1'b1; req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hs_cycle: got ready %b v %b expected 0000/1", req_ready, rsp_valid); end
    @(negedge clk); rsp_ready = 1'b0; #1;
    checks++; if (req_ready !== 4'b0010 || busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_after_hs: got ready %b busy %b v %b expected 0010/0/0", req_ready, busy, rsp_valid); end
    req_valid = '0;
  endtask

  // A reset during the second BUSY cycle drops the in-flight op, and no response appears afterwards.
  task automatic test_reset_busy();
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rb_grant: got %b expected 0010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (dbg_rr_ptr !== 2'd2) begin failures++; $display("FAIL rb_ptr_pre: got %0d expected 2", dbg_rr_ptr); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || dbg_rr_ptr !== 2'd0) begin failures++; $display("FAIL rb_after: got busy %b v %b ptr %0d expected 0/0/0", busy, rsp_valid, dbg_rr_ptr); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rb_no_rsp_%0d: got %b expected 0", i, rsp_valid); end
    end
  endtask

  // Randomized run checked against a transaction timeline: accept at t, BUSY for t+1..t+ADD_LAT, response from t+ADD_LAT+1.
  task automatic test_random();
    int          m_ptr   = 0;
    int          m_phase = 0;
    int          g;
    bit          found;
    logic [3:0]  exp_rdy;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [127:0] sh;
    logic [W-1:0] exp_t;
    int          n_rsp = 0;
    do_reset();
    exp_q.delete();
    m_a = '0; m_b = '0;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      req_valid = 4'($urandom_range(0, 15));
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (m_phase == 0) begin
        found = 1'b0; g = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && ((req_valid >> ((m_ptr + k) % NUM_REQ)) & 4'b1) != 4'b0) begin
            found = 1'b1; g = (m_ptr + k) % NUM_REQ;
          end
        end
        exp_rdy = found ? 4'(1 << g) : 4'b0;
        checks++; if (req_ready !== exp_rdy || busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rand_idle c%0d: got ready %b busy %b v %b expected %b/0/0", c, req_ready, busy, rsp_valid, exp_rdy); end
        checks++; if (dbg_rr_ptr !== 2'(m_ptr)) begin failures++; $display("FAIL rand_ptr c%0d: got %0d expected %0d", c, dbg_rr_ptr, m_ptr); end
        if (found) begin
          sh = req_a >> (32 * g); m_a = sh[31:0];
          sh = req_b >> (32 * g); m_b = sh[31:0];
          exp_q.push_back({2'(g), adder_fn(m_a, m_b)});
          m_ptr = (g + 1) % NUM_REQ;
          m_phase = 1;
        end
      end else if (m_phase <= ADD_LAT) begin
        checks++; if (req_ready !== 4'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rand_busy c%0d: got ready %b busy %b v %b expected 0000/1/0", c, req_ready, busy, rsp_valid); end
        checks++; if (fpa_a !== m_a || fpa_b !== m_b) begin failures++; $display("FAIL rand_fpa c%0d: got %h/%h expected %h/%h", c, fpa_a, fpa_b, m_a, m_b); end
        m_phase++;
      end else begin
        checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0) begin failures++; $display("FAIL rand_resp c%0d: got v %b ready %b expected 1/0000", c, rsp_valid, req_ready); end
        if (rsp_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL rand_sb_empty c%0d: got id %0d data %h expected none", c, rsp_id, rsp_data);
          end else begin
            exp_t = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== exp_t) begin failures++; $display("FAIL rand_sb c%0d: got id %0d data %h expected id %0d data %h", c, rsp_id, rsp_data, exp_t[W-1:32], exp_t[31:0]); end
          end
          n_rsp++;
          m_phase = 0;
        end
      end
    end
    checks++; if (n_rsp < 20) begin failures++; $display("FAIL rand_rsp_count: got %0d expected >=20", n_rsp); end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_basic();
    test_rr_order();
    test_ptr_wrap();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
